// File: rtl/alarma_sirena.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alarma_sirena : siren/LED sequencer (entry delay, siren burst, pause, lockout)
// Rev 1.0
// ---------------------------------------------------------------------------
module alarma_sirena #(
   parameter int PRESC   = 1000,
   parameter int T_ENT   = 8,
   parameter int T_SIR   = 30,
   parameter int T_PAU   = 5,
   parameter int MAX_ACT = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       c,
   input  logic       a,
   output logic       siren,
   output logic       led,
   output logic [2:0] estado
);
   localparam int T_MAX_EP = (T_ENT > T_SIR) ? T_ENT : T_SIR;
   localparam int T_MAX    = (T_MAX_EP > T_PAU) ? T_MAX_EP : T_PAU;
   localparam int TW       = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam int PW       = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam int NW       = $clog2(MAX_ACT + 1);

   localparam logic [2:0] DESARMADA = 3'd0;
   localparam logic [2:0] VIGILANDO = 3'd1;
   localparam logic [2:0] RETARDO   = 3'd2;
   localparam logic [2:0] SONANDO   = 3'd3;
   localparam logic [2:0] PAUSA     = 3'd4;
   localparam logic [2:0] BLOQUEO   = 3'd5;

   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
   localparam logic [TW-1:0] ENT_LAST   = TW'(T_ENT - 1);
   localparam logic [TW-1:0] SIR_LAST   = TW'(T_SIR - 1);
   localparam logic [TW-1:0] PAU_LAST   = TW'(T_PAU - 1);
   localparam logic [NW-1:0] ACT_LIMIT  = NW'(MAX_ACT);

   logic [2:0]    state;
   logic [2:0]    next_state;
   logic [PW-1:0] presc;
   logic [TW-1:0] timer;
   logic [NW-1:0] n_act;
   logic          tick;
   logic          siren_nxt;
   logic          led_nxt;

   assign tick   = (presc == PRESC_LAST);
   assign estado = state;

   // Any state change restarts the time base so each timed state lasts T*PRESC cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= DESARMADA;
         presc <= '0;
         timer <= '0;
         n_act <= '0;
         siren <= 1'b0;
         led   <= 1'b0;
      end else begin
         state <= next_state;
         siren <= siren_nxt;
         led   <= led_nxt;
         if (next_state != state) begin
            presc <= '0;
            timer <= '0;
         end else if (tick) begin
            presc <= '0;
            timer <= timer + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
         if (next_state == DESARMADA) begin
            n_act <= '0;
         end else if (state == RETARDO && next_state == SONANDO && n_act != ACT_LIMIT) begin
            n_act <= n_act + 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      if (!c) begin
         next_state = DESARMADA;
      end else begin
         case (state)
            DESARMADA: next_state = VIGILANDO;
            VIGILANDO: if (a) next_state = RETARDO;
            RETARDO:   if (tick && timer == ENT_LAST) next_state = SONANDO;
            SONANDO:   if (tick && timer == SIR_LAST) next_state = PAUSA;
            PAUSA: begin
               if (tick && timer == PAU_LAST)
                  next_state = (n_act == ACT_LIMIT) ? BLOQUEO : VIGILANDO;
            end
            BLOQUEO:   next_state = BLOQUEO;
            default:   next_state = DESARMADA;
         endcase
      end
   end

   // Outputs are computed from next_state so they register on the same edge as estado.
   always_comb begin
      siren_nxt = (next_state == SONANDO);
      led_nxt   = 1'b0;
      case (next_state)
         VIGILANDO, SONANDO, PAUSA: led_nxt = 1'b1;
         RETARDO, BLOQUEO:          led_nxt = (next_state != state) ? 1'b1 : (led ^ tick);
         default:                   led_nxt = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_alarma_sirena.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alarma_sirena : scoreboard bench for alarma_sirena (small and default timing)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alarma_sirena;
   localparam int PRESC   = 2;
   localparam int T_ENT   = 3;
   localparam int T_SIR   = 4;
   localparam int T_PAU   = 2;
   localparam int MAX_ACT = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       c = 1'b1;
   logic       a = 1'b1;
   logic       siren;
   logic       led;
   logic [2:0] estado;
   logic       c2 = 1'b0;
   logic       a2 = 1'b0;
   logic       siren2;
   logic       led2;
   logic [2:0] estado2;

   int total = 0;
   int bad   = 0;
   logic [4:0] sb_q[$];

   always #5 clk = ~clk;

   alarma_sirena #(
      .PRESC(PRESC), .T_ENT(T_ENT), .T_SIR(T_SIR), .T_PAU(T_PAU), .MAX_ACT(MAX_ACT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .c(c), .a(a),
      .siren(siren), .led(led), .estado(estado)
   );

   alarma_sirena dut_def (
      .clk(clk), .reset_n(reset_n), .c(c2), .a(a2),
      .siren(siren2), .led(led2), .estado(estado2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: counts cycles spent in the current state.
   initial begin
      logic [2:0] m_st, nxt;
      int m_cnt, m_nact;
      logic m_led;
      m_st = 3'd0; m_cnt = 0; m_nact = 0;
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            m_st = 3'd0; m_cnt = 0; m_nact = 0;
         end else begin
            nxt = m_st;
            if (!c) nxt = 3'd0;
            else case (m_st)
               3'd0: nxt = 3'd1;
               3'd1: if (a) nxt = 3'd2;
               3'd2: if (m_cnt == T_ENT * PRESC - 1) nxt = 3'd3;
               3'd3: if (m_cnt == T_SIR * PRESC - 1) nxt = 3'd4;
               3'd4: if (m_cnt == T_PAU * PRESC - 1) nxt = (m_nact == MAX_ACT) ? 3'd5 : 3'd1;
               3'd5: nxt = 3'd5;
               default: nxt = 3'd0;
            endcase
            if (nxt == 3'd0) m_nact = 0;
            else if (m_st == 3'd2 && nxt == 3'd3 && m_nact < MAX_ACT) m_nact++;
            if (nxt != m_st) m_cnt = 0; else m_cnt++;
            m_st = nxt;
         end
         if (m_st == 3'd1 || m_st == 3'd3 || m_st == 3'd4) m_led = 1'b1;
         else if (m_st == 3'd2 || m_st == 3'd5) m_led = ((m_cnt / PRESC) % 2) == 0;
         else m_led = 1'b0;
         sb_q.push_back({m_st, m_st == 3'd3, m_led});
      end
   end

   initial begin
      logic [4:0] e;
      forever begin
         @(negedge clk);
         chk("sb_depth", sb_q.size(), 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_out", {estado, siren, led}, e);
         end
      end
   end

   task automatic wait_state(input logic [2:0] st, input int bound);
      int n = 0;
      while (estado != st && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("wait_state", estado, st);
   endtask

   initial begin
      int n, bursts;
      logic prev;
      // 1: reset held with c=1, a=1
      repeat (3) @(negedge clk);
      chk("rst_estado", estado, 0);
      chk("rst_siren", siren, 0);
      chk("rst_led", led, 0);
      reset_n = 1'b1;
      a = 1'b0;
      @(negedge clk);
      chk("arm_estado", estado, 1);

      // 2: one-cycle pulse on a, entry delay and burst lengths
      a = 1'b1;
      @(negedge clk);
      a = 1'b0;
      wait_state(3'd2, 10);
      n = 0;
      while (estado == 3'd2 && n < 50) begin @(negedge clk); n++; end
      chk("ret_len", n, 6);
      n = 0;
      while (siren && n < 50) begin @(negedge clk); n++; end
      chk("sir_len", n, 8);
      wait_state(3'd1, 20);

      // 3: disarm in cycle 3 of SONANDO
      a = 1'b1;
      @(negedge clk);
      a = 1'b0;
      wait_state(3'd3, 20);
      repeat (2) @(negedge clk);
      c = 1'b0;
      @(negedge clk);
      chk("disarm_estado", estado, 0);
      chk("disarm_siren", siren, 0);

      // 4: re-arm with a stuck high -> two bursts then lockout
      c = 1'b1;
      a = 1'b1;
      bursts = 0;
      prev = 1'b0;
      n = 0;
      while (estado != 3'd5 && n < 200) begin
         @(negedge clk);
         if (siren && !prev) bursts++;
         prev = siren;
         n++;
      end
      chk("lock_estado", estado, 5);
      chk("lock_bursts", bursts, 2);
      n = 0;
      repeat (100) begin @(negedge clk); if (siren) n++; end
      chk("lock_silent", n, 0);
      c = 1'b0;
      @(negedge clk);
      chk("unlock_estado", estado, 0);

      // 5: asynchronous reset during SONANDO
      c = 1'b1;
      wait_state(3'd3, 30);
      #2 reset_n = 1'b0;
      #1 chk("async_siren", siren, 0);
      chk("async_estado", estado, 0);
      @(negedge clk);
      reset_n = 1'b1;
      c = 1'b0;
      a = 1'b0;

      // 6: default timing, entry delay = 8 ticks of 1000 cycles
      c2 = 1'b1;
      a2 = 1'b1;
      n = 0;
      while (estado2 != 3'd2 && n < 20) begin @(negedge clk); n++; end
      chk("def_retardo", estado2, 2);
      a2 = 1'b0;
      n = 0;
      while (!siren2 && n < 9000) begin @(negedge clk); n++; end
      chk("def_entry", n, 8000);
      chk("def_estado", estado2, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
